// File: rtl/score_glyph_scheduler.sv
// rtl/score_glyph_scheduler.sv - score readout: binary-to-BCD per frame plus glyph ROM addressing per pixel
// Stage 1 addresses the ROM from the scan position, stage 2 registers the returned dot.
module score_glyph_scheduler #(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W    = 14,
  parameter int ORIGIN_X   = 16,
  parameter int ORIGIN_Y   = 8,
  parameter int GLYPH_W    = 30,
  parameter int GLYPH_H    = 40
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_start,
  input  logic [SCORE_W-1:0] i_score,
  input  logic               i_pix_valid,
  input  logic [9:0]         i_px,
  input  logic [9:0]         i_py,
  output logic [4:0]         o_sym_x,
  output logic [5:0]         o_sym_y,
  output logic [3:0]         o_sym_type,
  input  logic               i_sym_dot,
  output logic               o_pix_valid,
  output logic               o_pix_on,
  output logic               o_busy
);
  localparam int BCD_W   = 4 * NUM_DIGITS;
  localparam int CNT_W   = $clog2(SCORE_W + 1);
  localparam int MAX_VAL = 10 ** NUM_DIGITS - 1;

  typedef enum logic {IDLE, CONV} state_t;
  state_t state_q, state_d;

  logic [SCORE_W-1:0] bin_q, bin_shift, sat;
  logic [BCD_W-1:0]   bcd_q, bcd_adj, bcd_shift, digits_q;
  logic [CNT_W-1:0]   cnt_q;

  assign sat = (32'(i_score) > MAX_VAL) ? SCORE_W'(MAX_VAL) : i_score;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_frame_start) state_d = CONV;
      CONV:    if (cnt_q == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state_q == CONV);
  end

  // Shift-add-3: bias every nibble >= 5 before the shift so it carries into the next digit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_shift, bin_shift} = {bcd_adj, bin_q} << 1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
    end else if (state_q == IDLE) begin
      if (i_frame_start) begin
        bin_q <= sat;
        bcd_q <= '0;
        cnt_q <= CNT_W'(SCORE_W);
      end
    end else begin
      bin_q <= bin_shift;
      bcd_q <= bcd_shift;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) digits_q <= bcd_shift;
    end
  end

  logic [10:0] dx, dy;
  logic [4:0]  off_x;
  logic [3:0]  sel_type;
  logic        in_box, lead_zero, blank;
  logic        pix_valid_q, in_glyph_q;

  assign dx = {1'b0, i_px} - 11'(ORIGIN_X);
  assign dy = {1'b0, i_py} - 11'(ORIGIN_Y);
  assign in_box = i_pix_valid && !dx[10] && (dx < 11'(NUM_DIGITS * GLYPH_W))
                  && !dy[10] && (dy < 11'(GLYPH_H));

  // Cell select by ascending thresholds; the last threshold passed names the cell.
  always_comb begin
    off_x     = dx[4:0];
    sel_type  = digits_q[BCD_W-1 -: 4];
    lead_zero = (sel_type == 4'd0);
    blank     = lead_zero && (NUM_DIGITS > 1);
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (dx >= 11'(k * GLYPH_W)) begin
        off_x     = 5'(dx - 11'(k * GLYPH_W));
        sel_type  = digits_q[BCD_W-1-4*k -: 4];
        lead_zero = lead_zero && (sel_type == 4'd0);
        blank     = lead_zero && (k < NUM_DIGITS - 1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sym_x     <= '0;
      o_sym_y     <= '0;
      o_sym_type  <= '0;
      pix_valid_q <= 1'b0;
      in_glyph_q  <= 1'b0;
      o_pix_valid <= 1'b0;
      o_pix_on    <= 1'b0;
    end else begin
      pix_valid_q <= i_pix_valid;
      in_glyph_q  <= in_box && !blank;
      if (in_box) begin
        o_sym_x    <= off_x;
        o_sym_y    <= dy[5:0];
        o_sym_type <= sel_type;
      end else begin
        o_sym_x    <= '0;
        o_sym_y    <= '0;
        o_sym_type <= '0;
      end
      o_pix_valid <= pix_valid_q;
      o_pix_on    <= in_glyph_q && i_sym_dot;
    end
  end
endmodule

// File: tb/tb_score_glyph_scheduler.sv
// tb/tb_score_glyph_scheduler.sv - randomized bench with a behavioural score/glyph model
module tb_score_glyph_scheduler;
  localparam int OX = 16, OY = 8, W = 30, H = 40, ND = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [13:0] score = 14'd1234;
  logic        pix_valid = 1'b0;
  logic [9:0]  px = '0, py = '0;
  logic [4:0]  sym_x;
  logic [5:0]  sym_y;
  logic [3:0]  sym_type;
  logic        sym_dot;
  logic        out_valid, pix_on, busy;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  bit rom_on = 1'b1;

  always #5 clk = ~clk;

  score_glyph_scheduler dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start), .i_score(score),
    .i_pix_valid(pix_valid), .i_px(px), .i_py(py),
    .o_sym_x(sym_x), .o_sym_y(sym_y), .o_sym_type(sym_type), .i_sym_dot(sym_dot),
    .o_pix_valid(out_valid), .o_pix_on(pix_on), .o_busy(busy)
  );

  function automatic bit rom_dot(int t, int x, int y);
    return rom_on ? 1'b1 : (((t * 7 + x * 3 + y) % 5) < 2);
  endfunction

  assign sym_dot = rom_dot(int'(sym_type), int'(sym_x), int'(sym_y));

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: decimal digits by division, cell by division, busy by a countdown.
  int m_disp[ND];
  int m_left, m_val;
  int m_x, m_y, m_type;
  bit m_glyph, m_valid, m_pv, m_on;

  always @(posedge clk or negedge rst_n) begin
    int k, dxi, dyi;
    bit blank;
    if (!rst_n) begin
      for (int i = 0; i < ND; i++) m_disp[i] <= 0;
      m_left <= 0; m_val <= 0;
      m_x <= 0; m_y <= 0; m_type <= 0;
      m_glyph <= 0; m_valid <= 0; m_pv <= 0; m_on <= 0;
    end else begin
      m_on  <= m_glyph && rom_dot(m_type, m_x, m_y);
      m_pv  <= m_valid;
      m_valid <= pix_valid;
      dxi = int'(px) - OX;
      dyi = int'(py) - OY;
      if (pix_valid && dxi >= 0 && dxi < ND * W && dyi >= 0 && dyi < H) begin
        k = dxi / W;
        blank = (k < ND - 1);
        for (int i = 0; i <= k; i++) if (m_disp[i] != 0) blank = 1'b0;
        m_x <= dxi % W; m_y <= dyi; m_type <= m_disp[k]; m_glyph <= !blank;
      end else begin
        m_x <= 0; m_y <= 0; m_type <= 0; m_glyph <= 0;
      end
      if (m_left == 0) begin
        if (frame_start) begin
          m_val  <= (int'(score) > 9999) ? 9999 : int'(score);
          m_left <= 14;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1)
          for (int i = 0; i < ND; i++) m_disp[i] <= (m_val / (10 ** (ND - 1 - i))) % 10;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("sym_x", int'(sym_x), m_x);
      check("sym_y", int'(sym_y), m_y);
      check("sym_type", int'(sym_type), m_type);
      check("busy", int'(busy), int'(m_left != 0));
      check("pix_valid", int'(out_valid), int'(m_pv));
      check("pix_on", int'(pix_on), int'(m_on));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int s);
    score = 14'(s);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    if (n >= 100) check("busy_timeout", 1, 0);
  endtask

  task automatic probe(input int x, input int y, input int et, input int ex, input int ey, input int eon);
    pix_valid = 1'b1; px = 10'(x); py = 10'(y);
    tick();
    pix_valid = 1'b0;
    check("lit_type", int'(sym_type), et);
    check("lit_x", int'(sym_x), ex);
    check("lit_y", int'(sym_y), ey);
    tick();
    check("lit_on", int'(pix_on), eon);
  endtask

  task automatic scan(input int n, input bit frames);
    for (int i = 0; i < n; i++) begin
      pix_valid = ($urandom_range(0, 3) != 0);
      px = 10'($urandom_range(0, 150));
      py = 10'($urandom_range(0, 60));
      frame_start = frames && ($urandom_range(0, 40) == 0);
      score = 14'($urandom_range(0, 16383));
      tick();
    end
    frame_start = 1'b0;
    pix_valid = 1'b0;
  endtask

  initial begin
    int n;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    tick();
    probe(OX + 5, OY + 5, 0, 5, 5, 0);
    probe(OX + 95, OY + 3, 0, 5, 3, 1);
    scan(200, 1'b0);

    frame(1234);
    wait_idle(n);
    check("busy_len", n, 14);
    probe(OX + 65, OY + 7, 3, 5, 7, 1);
    probe(OX, OY, 1, 0, 0, 1);
    probe(OX + 119, OY + 39, 4, 29, 39, 1);
    probe(OX - 1, OY, 0, 0, 0, 0);
    probe(OX + 120, OY, 0, 0, 0, 0);
    probe(OX, OY + 40, 0, 0, 0, 0);
    probe(OX, OY - 1, 0, 0, 0, 0);

    frame(16383);
    wait_idle(n);
    probe(OX + 40, OY + 2, 9, 10, 2, 1);
    frame(7);
    wait_idle(n);
    probe(OX + 61, OY + 39, 0, 1, 39, 0);
    probe(OX + 119, OY + 39, 7, 29, 39, 1);

    frame(1234);
    repeat (4) tick();
    frame(42);
    wait_idle(n);
    check("ignored_len", n, 9);
    probe(OX + 70, OY + 1, 3, 10, 1, 1);
    frame(42);
    wait_idle(n);
    probe(OX + 70, OY + 1, 4, 10, 1, 1);
    probe(OX + 35, OY + 1, 0, 5, 1, 0);

    rom_on = 1'b0;
    scan(1500, 1'b1);
    wait_idle(n);
    rom_on = 1'b1;

    frame(9999);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    probe(OX + 95, OY, 0, 5, 0, 1);
    probe(OX + 5, OY, 0, 5, 0, 0);
    scan(200, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/score_glyph_scheduler.md
Name: score_glyph_scheduler

Overview:
- Sequences the digit-glyph ROM for the on-screen score readout. The ROM is 30x40 glyphs; types 0-9 are digits and type 10 is the status shell.
- Once per frame, latches a binary score and converts it to BCD with a multi-cycle shift-add-3 engine.
- For every scanned pixel, computes the glyph type and the in-glyph x/y offset that drive the ROM, then registers the returned dot into a pixel-on flag.
- Sits between the VGA timing/pixel-pipeline and the glyph ROM.

Parameters:
- NUM_DIGITS, 4, number of decimal digit cells, drawn left to right MSD first.
- SCORE_W, 14, width of the binary score input.
- ORIGIN_X, 16, screen x of the readout's left edge.
- ORIGIN_Y, 8, screen y of the readout's top edge.
- GLYPH_W, 30, glyph cell width in pixels.
- GLYPH_H, 40, glyph cell height in pixels.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_frame_start  in  1  one-cycle pulse at the start of vertical blank
- i_score  in  SCORE_W  binary score, sampled on i_frame_start
- i_pix_valid  in  1  i_px/i_py are an active pixel this cycle
- i_px  in  10  screen x
- i_py  in  10  screen y
- o_sym_x  out  5  glyph column to ROM, 0..GLYPH_W-1
- o_sym_y  out  6  glyph row to ROM, 0..GLYPH_H-1
- o_sym_type  out  4  glyph select to ROM, 0..9
- i_sym_dot  in  1  ROM dot, combinational from o_sym_*
- o_pix_valid  out  1  o_pix_on is valid for the pixel presented 2 cycles earlier
- o_pix_on  out  1  pixel belongs to a lit digit stroke
- o_busy  out  1  BCD conversion in progress

Behaviour:
- Reset (async, i_rst_n=0):
  - o_sym_x=0, o_sym_y=0, o_sym_type=0.
  - o_pix_valid=0, o_pix_on=0, o_busy=0.
  - FSM=IDLE. Displayed digit registers all 0, so the screen shows "0".
- Conversion FSM, states IDLE and CONV:
  - IDLE, on i_frame_start: capture min(i_score, 10^NUM_DIGITS-1), clear the BCD accumulator, load bit counter = SCORE_W, go to CONV. o_busy=1 from the next cycle.
  - CONV, each cycle: for each BCD nibble >=5, add 3; then shift {BCD, bin} left by 1; decrement the counter.
  - CONV, after exactly SCORE_W cycles: copy all NUM_DIGITS nibbles into the displayed digit registers in one cycle, return to IDLE, drop o_busy.
  - i_frame_start during CONV is ignored. The running conversion completes unchanged.
  - Displayed digits change only on that single commit cycle. There are no partial updates.
  - Reset mid-CONV aborts the conversion; displayed digits return to 0.
- Pixel pipeline, stage 1 (registered, 1 cycle):
  - dx = i_px - ORIGIN_X; dy = i_py - ORIGIN_Y.
  - in_box = i_pix_valid && i_px >= ORIGIN_X && i_px < ORIGIN_X + NUM_DIGITS*GLYPH_W && i_py >= ORIGIN_Y && i_py < ORIGIN_Y + GLYPH_H.
  - Cell k = floor(dx/GLYPH_W), found by unrolled comparisons. No divider.
  - o_sym_x = dx - k*GLYPH_W; o_sym_y = dy; o_sym_type = digit[k], where cell 0 is the most significant digit.
  - Leading-zero blanking: cell k is blanked when all digits from cell 0 through cell k are 0 and k < NUM_DIGITS-1. The units cell is never blanked.
  - Register in_glyph = in_box && !blank together with i_pix_valid.
  - Outside the box: o_sym_x=0, o_sym_y=0, o_sym_type=0, in_glyph=0.
- Pixel pipeline, stage 2 (registered):
  - o_pix_on <= in_glyph_q && i_sym_dot.
  - o_pix_valid <= pix_valid_q.
- Latency: a pixel presented at cycle N yields o_pix_on/o_pix_valid at cycle N+2. Throughput is one pixel per cycle with no stalls.
- Digit registers read by stage 1 update only at the commit cycle, so a frame never mixes old and new digits as long as conversion finishes within blanking. SCORE_W cycles is well under blanking length.
- Width rules:
  - dx/dy are computed in 11 bits; a negative result is treated as outside the box.
  - o_sym_x/o_sym_y are truncated to 5/6 bits only after the range check.

Test Plan:
- Reset with i_score=1234 and no frame pulse → scan the box: only the units cell draws, with type 0; cells 0-2 have in_glyph=0 and o_pix_on=0.
- i_frame_start with i_score=1234 → o_busy high for exactly 14 cycles; then digits=1,2,3,4. Pixel (ORIGIN_X+65, ORIGIN_Y+7) → o_sym_type=3, o_sym_x=5, o_sym_y=7 one cycle later.
- i_score=16383 → saturates and displays 9999. i_score=7 → cells 0-2 blanked, cell 3 has type 7.
- Second i_frame_start 5 cycles into CONV with i_score=42 → ignored; result stays 1234; the next pulse after o_busy falls yields 0042, shown as "42".
- Pixel stream with the ROM model tied dot=1 → o_pix_on is 1 exactly 2 cycles after in-box valid pixels; boundary pixels x=ORIGIN_X-1, x=ORIGIN_X+120, y=ORIGIN_Y+40 give 0.
- Assert i_rst_n low mid-CONV → o_busy=0 and digits=0 immediately; outputs stay at reset values until the next frame pulse.
